game_status_tracker: RTL



---
 rtl/game_status_tracker.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/game_status_tracker.sv
// Game status tracker: edge-driven kill counter with BCD score, lives with a
// post-hit invulnerability cooldown, and the PLAYING/PAUSED/WON/LOST status FSM.
module game_status_tracker #(
    parameter int N_ENEMIES    = 10,
    parameter int START_LIVES  = 3,
    parameter int HIT_COOLDOWN = 50_000_000,
    parameter int MAX_SCORE    = 99
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pausa,
    input  logic [N_ENEMIES-1:0] enemy_alive,
    input  logic                 ship_hit,
    output logic [6:0]           score,
    output logic [7:0]           score_bcd,
    output logic [1:0]           vidas,
    output logic                 perdeu,
    output logic                 venceu,
    output logic [1:0]           state,
    output logic                 invuln,
    output logic                 kill_pulse
);

    // state   | meaning
    // PLAYING | normal play: kills, hits and cooldown all active
    // PAUSED  | kills still count, hits discarded, cooldown frozen
    // WON     | all enemies dead; everything frozen until reset
    // LOST    | last life taken; everything frozen until reset
    typedef enum logic [1:0] {
        ST_PLAYING = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_WON     = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    localparam int CW = $clog2(HIT_COOLDOWN + 1);
    localparam int KW = $clog2(N_ENEMIES + 1);

    state_t                state_q, state_d;
    logic [6:0]            score_q, score_d;
    logic [7:0]            bcd_q, bcd_d;
    logic [1:0]            vidas_q, vidas_d;
    logic [CW-1:0]         cool_q, cool_d;
    logic                  invuln_q, invuln_d;
    logic                  kill_q, kill_d;
    logic                  perdeu_q, perdeu_d;
    logic                  venceu_q, venceu_d;
    logic [N_ENEMIES-1:0]  prev_alive_q;
    logic                  prev_hit_q;

    logic [N_ENEMIES-1:0]  fell;
    logic [KW-1:0]         kills;
    logic [7:0]            score_sum;
    logic [6:0]            score_sat;
    logic                  hit_edge;
    logic                  hit_accept;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 7'd10);
        units = 4'(v % 7'd10);
        return {tens, units};
    endfunction

    always_comb begin
        fell  = prev_alive_q & ~enemy_alive;
        kills = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            kills = kills + KW'(fell[i]);
        end
        // 7-bit score plus carry, clamped before it reaches the register
        score_sum = {1'b0, score_q} + 8'(kills);
        score_sat = (score_sum > 8'(MAX_SCORE)) ? 7'(MAX_SCORE) : score_sum[6:0];
    end

    assign hit_edge   = ship_hit & ~prev_hit_q;
    assign hit_accept = (state_q == ST_PLAYING) && hit_edge &&
                        (cool_q == '0) && (vidas_q != 2'd0);

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        bcd_d   = bcd_q;
        vidas_d = vidas_q;
        cool_d  = cool_q;
        kill_d  = 1'b0;

        if (((state_q == ST_PLAYING) || (state_q == ST_PAUSED)) && (kills != '0)) begin
            score_d = score_sat;
            bcd_d   = to_bcd(score_sat);
            kill_d  = 1'b1;
        end

        if ((state_q == ST_PLAYING) && (cool_q != '0)) begin
            cool_d = cool_q - CW'(1);
        end

        if (hit_accept) begin
            vidas_d = vidas_q - 2'd1;
            cool_d  = CW'(HIT_COOLDOWN);
        end

        case (state_q)
            ST_PLAYING: begin
                if (hit_accept && (vidas_q == 2'd1)) begin
                    state_d = ST_LOST;
                end else if (enemy_alive == '0) begin
                    state_d = ST_WON;
                end else if (pausa) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                // a win reached while paused is taken on the next PLAYING cycle
                if (!pausa) begin
                    state_d = ST_PLAYING;
                end
            end
            default: ;
        endcase

        invuln_d = (cool_d != '0);
        perdeu_d = (state_d == ST_LOST);
        venceu_d = (state_d == ST_WON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_PLAYING;
            score_q  <= '0;
            bcd_q    <= '0;
            vidas_q  <= 2'(START_LIVES);
            cool_q   <= '0;
            invuln_q <= 1'b0;
            kill_q   <= 1'b0;
            perdeu_q <= 1'b0;
            venceu_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            bcd_q    <= bcd_d;
            vidas_q  <= vidas_d;
            cool_q   <= cool_d;
            invuln_q <= invuln_d;
            kill_q   <= kill_d;
            perdeu_q <= perdeu_d;
            venceu_q <= venceu_d;
        end
        // edge history tracks the inputs during reset too, so release is edge-free
        prev_alive_q <= enemy_alive;
        prev_hit_q   <= ship_hit;
    end

    assign score      = score_q;
    assign score_bcd  = bcd_q;
    assign vidas      = vidas_q;
    assign perdeu     = perdeu_q;
    assign venceu     = venceu_q;
    assign state      = state_q;
    assign invuln     = invuln_q;
    assign kill_pulse = kill_q;

endmodule
